// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: shares one memory port between the pipeline MEM
// stage (CPU) and a debug/loader port (DBG). The CPU normally wins; a waiting
// debug request is forced through after STARVE_LIMIT consecutive CPU grants.
// Grant selection is combinational. Debug completion is a registered one-cycle
// ack, and the arbiter refuses to re-grant debug during that ack cycle.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [10:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [10:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic [10:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_reg;
    logic [3:0]  starve_cnt_reg;
    logic        dbg_ack_reg;
    logic [31:0] dbg_rdata_reg;

    logic        dbg_eligible;
    logic        grant_dbg;
    logic        grant_cpu;
    logic        mem_we_sel;

    // Debug may only win from IDLE; it beats a live CPU request only once the
    // CPU has used up its allowance of back-to-back grants.
    assign dbg_eligible = dbg_req && (state_reg == ST_IDLE);
    assign grant_dbg    = dbg_eligible && (!cpu_req || (starve_cnt_reg == LIMIT));
    assign grant_cpu    = cpu_req && !grant_dbg;

    // Memory port steering for the current owner; unused port is driven to zero.
    always_comb begin
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we_sel = 1'b0;
        cpu_stall  = 1'b0;
        if (grant_dbg) begin
            mem_addr   = dbg_addr;
            mem_wdata  = dbg_wdata;
            mem_we_sel = dbg_we;
            cpu_stall  = cpu_req;
        end else if (grant_cpu) begin
            mem_addr   = cpu_addr;
            mem_wdata  = cpu_wdata;
            mem_we_sel = cpu_we;
        end
    end

    // Reset blocks any memory write straight away, without waiting for a clock.
    assign mem_we    = mem_we_sel && !rst;
    assign cpu_rdata = mem_rdata;
    assign dbg_ack   = dbg_ack_reg;
    assign dbg_rdata = dbg_rdata_reg;

    // Debug handshake FSM, captured read data and CPU starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            dbg_ack_reg    <= 1'b0;
            dbg_rdata_reg  <= '0;
            starve_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_dbg) begin
                        state_reg   <= ST_ACK;
                        dbg_ack_reg <= 1'b1;
                        if (!dbg_we) begin
                            dbg_rdata_reg <= mem_rdata;
                        end
                    end
                end
                ST_ACK: begin
                    state_reg   <= ST_IDLE;
                    dbg_ack_reg <= 1'b0;
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    dbg_ack_reg <= 1'b0;
                end
            endcase

            // Counts CPU wins over a waiting debug request; the ack cycle does
            // not count because debug cannot be granted there anyway.
            if (grant_dbg || !dbg_req) begin
                starve_cnt_reg <= '0;
            end else if (grant_cpu && (state_reg == ST_IDLE) && (starve_cnt_reg != LIMIT)) begin
                starve_cnt_reg <= starve_cnt_reg + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter. An external RAM model (negedge write,
// combinational read) sits on the memory port. A reference model keeps its own
// copy of memory and applies each access in the order the arbiter completes it,
// queueing expected read data. A monitor compares DUT read data against the
// queues. Directed sections cover reset, grant timing and the starvation limit.
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [10:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_we;
    logic [10:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    // Posedges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // External data memory.
    logic [31:0] dev_mem [0:2047];
    assign mem_rdata = dev_mem[mem_addr];
    always @(negedge clk) begin
        if (mem_we) dev_mem[mem_addr] = mem_wdata;
    end

    // Reference state.
    logic [31:0] ref_mem [0:2047];
    logic [31:0] exp_dbg_rdata;
    logic [31:0] cpu_q[$];
    logic [31:0] dbg_q[$];
    logic        stall_prev;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Reference model, mid-cycle: apply completed accesses in arbitration order.
    // A debug access acked now was performed last cycle, when the CPU did not
    // own the memory, so it is applied before this cycle's CPU access.
    always @(posedge clk) begin
        #6;
        if (rst) begin
            exp_dbg_rdata = 32'h0;
            cpu_q.delete();
            dbg_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (dbg_ack) begin
                if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
                else        exp_dbg_rdata = ref_mem[dbg_addr];
                dbg_q.push_back(exp_dbg_rdata);
            end
            if (cpu_req && !cpu_stall) begin
                if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
                else        cpu_q.push_back(ref_mem[cpu_addr]);
            end
            // A stall is only legal because of a debug request, and never twice in a row.
            if (cpu_stall) begin
                check("stall_legal", 32'(dbg_req && !stall_prev), 32'd1);
            end
            stall_prev = cpu_stall;
        end
    end

    // Monitor, late in the cycle: compare whatever read data the DUT presents.
    always @(posedge clk) begin
        #8;
        if (!rst) begin
            if (dbg_ack) begin
                if (dbg_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dbg_q_empty: actual=ack required=queued expectation");
                end else begin
                    check("dbg_rdata", dbg_rdata, dbg_q.pop_front());
                end
            end
            if (cpu_req && !cpu_stall && !cpu_we) begin
                if (cpu_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL cpu_q_empty: actual=read required=queued expectation");
                end else begin
                    check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Both requesters held high from a clean start: CPU wins LIMIT cycles,
    // debug wins the next (stalling the CPU), ack follows, and it repeats.
    task automatic starve_pattern(input int reps);
        int ph;
        for (int k = 0; k < reps * (LIMIT + 2); k++) begin
            tick();
            if (k == 0) begin
                cpu_req  = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h002;
                dbg_req  = 1'b1; dbg_we = 1'b0; dbg_addr = 11'h003;
            end
            #1;
            ph = k % (LIMIT + 2);
            check($sformatf("starve_stall[%0d]", k), 32'(cpu_stall), 32'(ph == LIMIT));
            check($sformatf("starve_ack[%0d]", k), 32'(dbg_ack), 32'(ph == LIMIT + 1));
        end
        tick();
        cpu_req = 1'b0;
        dbg_req = 1'b0;
    endtask

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic        cpu_held;
    int          dbg_wait;
    logic [10:0] ra;

    initial begin
        for (int i = 0; i < 2048; i++) begin
            dev_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
            ref_mem[i] = dev_mem[i];
        end
        dev_mem[11'h7FF] = 32'h1234_5678;
        ref_mem[11'h7FF] = 32'h1234_5678;

        // Reset with a CPU write being requested.
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h001; cpu_wdata = 32'h1111_1111;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
        check("rst_dbg_rdata", dbg_rdata, 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        tick();
        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;

        // CPU write then read-back of the same word.
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h005; cpu_wdata = 32'hDEAD_BEEF;
        #1;
        check("cpu_wr_mem_we", 32'(mem_we), 32'd1);
        check("cpu_wr_mem_addr", 32'(mem_addr), 32'h005);
        check("cpu_wr_stall", 32'(cpu_stall), 32'd0);
        tick();
        cpu_we = 1'b0;
        #1;
        check("cpu_rd_back", cpu_rdata, 32'hDEAD_BEEF);
        tick();
        cpu_req = 1'b0;

        // Debug read with CPU idle, request held through the ack cycle.
        tick();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 11'h7FF;
        #1;
        check("dbg_rd_grant_addr", 32'(mem_addr), 32'h7FF);
        check("dbg_rd_no_ack_yet", 32'(dbg_ack), 32'd0);
        tick();
        #1;
        check("dbg_rd_ack", 32'(dbg_ack), 32'd1);
        check("dbg_rd_data", dbg_rdata, 32'h1234_5678);
        check("dbg_rd_no_regrant", 32'(mem_addr), 32'h000);
        tick();
        dbg_req = 1'b0;
        #1;
        check("dbg_ack_one_cycle", 32'(dbg_ack), 32'd0);

        // Debug write, then CPU read of that word in the ack cycle.
        tick();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 11'h0A0; dbg_wdata = 32'hCAFE_F00D;
        #1;
        check("dbg_wr_mem_we", 32'(mem_we), 32'd1);
        tick();
        dbg_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h0A0;
        #1;
        check("dbg_wr_ack", 32'(dbg_ack), 32'd1);
        check("dbg_wr_cpu_sees", cpu_rdata, 32'hCAFE_F00D);
        check("dbg_wr_rdata_kept", dbg_rdata, 32'h1234_5678);
        tick();
        cpu_req = 1'b0;

        // Starvation limit.
        starve_pattern(2);

        // Reset asserted during the ack cycle while the CPU requests a write.
        tick();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 11'h7FF; cpu_req = 1'b0;
        tick();
        check("pre_rst_ack", 32'(dbg_ack), 32'd1);
        rst = 1'b1; dbg_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h009; cpu_wdata = 32'h5555_AAAA;
        #1;
        check("mid_ack_rst_ack", 32'(dbg_ack), 32'd0);
        check("mid_ack_rst_we", 32'(mem_we), 32'd0);
        tick();
        check("rst_hold_we", 32'(mem_we), 32'd0);
        check("rst_hold_rdata", dbg_rdata, 32'h0);
        tick();
        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        starve_pattern(1);

        // Randomized traffic on a small address set to force collisions.
        cpu_held = 1'b0;
        dbg_wait = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (dbg_ack) begin
                check("dbg_wait_bound", 32'(dbg_wait <= LIMIT + 1), 32'd1);
                dbg_req = 1'b0;
                dbg_wait = 0;
            end
            if (!cpu_held) begin
                ra = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 7));
                cpu_req   = ($urandom_range(0, 99) < 60);
                cpu_we    = 1'($urandom);
                cpu_addr  = ra;
                cpu_wdata = $urandom;
            end
            if (!dbg_req && !dbg_ack && ($urandom_range(0, 99) < 25)) begin
                dbg_req   = 1'b1;
                dbg_we    = 1'($urandom);
                dbg_addr  = 11'($urandom_range(0, 7));
                dbg_wdata = $urandom;
                dbg_wait  = 0;
            end
            #3;
            cpu_held = cpu_req && cpu_stall;
            if (dbg_req) begin
                dbg_wait++;
                if (dbg_wait > LIMIT + 4) begin
                    total++; bad++;
                    $display("FAIL dbg_timeout: actual=%0d cycles required<=%0d", dbg_wait, LIMIT + 1);
                    dbg_req = 1'b0;
                    dbg_wait = 0;
                end
            end
        end

        // Drain, then every queued expectation must have been consumed.
        tick();
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        repeat (3) tick();
        check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        check("dbg_q_drained", 32'(dbg_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
